bus_demux_fifo: RTL and testbench

Buffered 1-to-2 bus demultiplexer: the steering counterpart of the team's 2:1 bus select mux. One input stream of WIDTH-bit words carries a per-word select bit; each word is routed into one of two independent output channels. Each channel has a DEPTH-entry FIFO and a valid/ready handshake, so one stalled consumer never blocks traffic destined for the other. Sits between a single producer and two consumers of the same bus.

---
 rtl/bus_demux_fifo_pkg.sv | 8 +
 rtl/bus_sync_fifo.sv | 41 ++++
 rtl/bus_demux_fifo.sv | 48 ++++
 tb/tb_bus_demux_fifo.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/bus_demux_fifo_pkg.sv
// bus_demux_fifo_pkg: shared defaults and channel constants for the buffered 1-to-2 demux
package bus_demux_fifo_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 2;
  localparam int CNT_W = 8;
  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;
endpackage

// File: rtl/bus_sync_fifo.sv
// bus_sync_fifo: single-clock FIFO with occupancy counter, guarded push/pop and registered head
module bus_sync_fifo
  import bus_demux_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_occ;
  logic w_push, w_pop;
  assign o_full = r_occ == FULL;
  assign o_empty = r_occ == '0;
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  assign o_head = r_mem[r_rptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_occ <= r_occ + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  // storage is deliberately left out of reset
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= i_data;
endmodule

// File: rtl/bus_demux_fifo.sv
// bus_demux_fifo: steers each input word into one of two buffered channels with delivery counters
module bus_demux_fifo
  import bus_demux_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic [CNT_W-1:0] out0_count,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0] out1_count
);
  logic w_full0, w_full1, w_empty0, w_empty1, w_push0, w_push1;
  logic [CNT_W-1:0] r_cnt0, r_cnt1;
  assign in_ready = in_sel ? !w_full1 : !w_full0;
  assign w_push0 = in_valid && in_ready && in_sel == CH0;
  assign w_push1 = in_valid && in_ready && in_sel == CH1;
  assign out0_valid = !w_empty0;
  assign out1_valid = !w_empty1;
  assign out0_count = r_cnt0;
  assign out1_count = r_cnt1;
  bus_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk(clk), .rst_n(rst_n), .i_push(w_push0), .i_data(in_data), .i_pop(out0_ready),
    .o_full(w_full0), .o_empty(w_empty0), .o_head(out0_data)
  );
  bus_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk(clk), .rst_n(rst_n), .i_push(w_push1), .i_data(in_data), .i_pop(out1_ready),
    .o_full(w_full1), .o_empty(w_empty1), .o_head(out1_data)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (out0_valid && out0_ready) r_cnt0 <= r_cnt0 + 1'b1;
      if (out1_valid && out1_ready) r_cnt1 <= r_cnt1 + 1'b1;
    end
endmodule

// File: tb/tb_bus_demux_fifo.sv
// tb_bus_demux_fifo: directed-vector self-checking bench for bus_demux_fifo (WIDTH=4, DEPTH=2)
module tb_bus_demux_fifo;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_sel = 0, out0_ready = 0, out1_ready = 0;
  logic in_ready, out0_valid, out1_valid;
  logic [3:0] in_data = 0, out0_data, out1_data;
  logic [7:0] out0_count, out1_count;
  int errs = 0, checks = 0;
  bus_demux_fifo #(.WIDTH(4), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_data(in_data), .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
    .out0_count(out0_count), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out1_data(out1_data), .out1_count(out1_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic drive(input logic v, input logic s, input logic [3:0] d);
    in_valid = v;
    in_sel = s;
    in_data = d;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_v0", out0_valid, 0);
    chk("rst_v1", out1_valid, 0);
    chk("rst_c0", out0_count, 0);
    chk("rst_c1", out1_count, 0);
    drive(1, 0, 4'hA);
    tick;
    drive(0, 0, 0);
    #1;
    chk("lat_v0", out0_valid, 1);
    chk("lat_d0", out0_data, 4'hA);
    chk("lat_v1", out1_valid, 0);
    out0_ready = 1;
    tick;
    out0_ready = 0;
    chk("pop_a_c0", out0_count, 1);
    chk("pop_a_v0", out0_valid, 0);
    drive(1, 0, 4'h1);
    tick;
    drive(1, 0, 4'h2);
    tick;
    drive(0, 0, 0);
    #1;
    chk("full0_rdy", in_ready, 0);
    chk("full0_head", out0_data, 4'h1);
    in_sel = 1;
    #1;
    chk("sel1_rdy", in_ready, 1);
    drive(1, 1, 4'h3);
    tick;
    drive(0, 1, 0);
    #1;
    chk("ch1_v", out1_valid, 1);
    chk("ch1_d3", out1_data, 4'h3);
    out1_ready = 1;
    tick;
    out1_ready = 0;
    chk("pop3_c1", out1_count, 1);
    drive(1, 1, 4'h4);
    tick;
    drive(1, 1, 4'h5);
    tick;
    drive(0, 1, 0);
    #1;
    chk("full1_rdy", in_ready, 0);
    chk("full1_head", out1_data, 4'h4);
    drive(1, 1, 4'h6);
    out1_ready = 1;
    #1;
    chk("full1_pop_rdy", in_ready, 0);
    tick;
    chk("c1_after4", out1_count, 2);
    chk("d1_5", out1_data, 4'h5);
    chk("rdy1_reopen", in_ready, 1);
    tick;
    drive(0, 1, 0);
    chk("c1_after5", out1_count, 3);
    chk("d1_6", out1_data, 4'h6);
    chk("v1_6", out1_valid, 1);
    tick;
    out1_ready = 0;
    chk("c1_after6", out1_count, 4);
    chk("v1_empty", out1_valid, 0);
    drive(1, 0, 4'h7);
    out0_ready = 1;
    #1;
    chk("full0_pop_rdy", in_ready, 0);
    tick;
    chk("c0_after1", out0_count, 2);
    chk("d0_2", out0_data, 4'h2);
    chk("rdy0_reopen", in_ready, 1);
    tick;
    drive(0, 0, 0);
    chk("c0_after2", out0_count, 3);
    chk("d0_7", out0_data, 4'h7);
    tick;
    chk("c0_after7", out0_count, 4);
    chk("v0_empty", out0_valid, 0);
    for (int i = 0; i < 260; i++) begin
      drive(1, 0, i[3:0]);
      tick;
      chk("stream_d", out0_data, i[3:0]);
    end
    drive(0, 0, 0);
    tick;
    out0_ready = 0;
    chk("wrap_c0", out0_count, 8);
    chk("wrap_v0", out0_valid, 0);
    drive(1, 0, 4'hB);
    tick;
    drive(1, 0, 4'hC);
    tick;
    drive(1, 1, 4'hD);
    tick;
    drive(1, 1, 4'hE);
    tick;
    drive(0, 0, 0);
    chk("pre_rst_v0", out0_valid, 1);
    chk("pre_rst_v1", out1_valid, 1);
    chk("pre_rst_rdy", in_ready, 0);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_v0", out0_valid, 0);
    chk("mid_rst_v1", out1_valid, 0);
    chk("mid_rst_c0", out0_count, 0);
    chk("mid_rst_c1", out1_count, 0);
    chk("mid_rst_rdy", in_ready, 1);
    rst_n = 1;
    drive(1, 1, 4'h9);
    tick;
    drive(0, 0, 0);
    chk("post_rst_v1", out1_valid, 1);
    chk("post_rst_d1", out1_data, 4'h9);
    chk("post_rst_v0", out0_valid, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
